uart_rx: RTL and testbench

Serial receive stage for the UART. It samples the asynchronous `serial_rx` line at 16x the baud rate, frames 8N1 characters LSB-first, and presents each received byte through a one-entry holding register with a valid/ready handshake. It sits directly upstream of the byte consumer and is the receive-side counterpart of the UART transmit path, sharing its clock, baud and divider conventions.

---
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 (or 8E1) UART receiver with a one-entry
// valid/ready holding register and one-cycle error/overrun pulses.
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames with an
// even-parity check; when undefined the frame is 8N1 and parity_error is 0.
module uart_rx #(
  parameter int CLOCK_HZ       = 12_000_000,
  parameter int BAUD_HZ        = 9_600,
  parameter int OVERSAMPLE_DIV = CLOCK_HZ / (BAUD_HZ * 16)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       parity_error,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rxs;
  logic [15:0] presc;
  logic        tick;
  logic [3:0]  phase;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        par_bad;

  assign tick = (presc == 16'(OVERSAMPLE_DIV - 1));

`ifdef UART_RX_PARITY_EN
  logic par_err;
  assign par_bad = par_err;
`else
  assign par_bad      = 1'b0;
  assign parity_error = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      // NOTE: non-blocking so the second flop takes the first flop's old value.
      rx_meta <= serial_rx;
      rxs     <= rx_meta;
    end
  end

  // Oversample prescaler; realigned to the start edge when leaving IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= 16'd0;
    end else if ((state == IDLE && !rxs) || tick) begin
      presc <= 16'd0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // Frame FSM, holding register handshake and registered status pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= 4'd0;
      bit_cnt     <= 3'd0;
      shift       <= 8'd0;
      rx_byte     <= 8'd0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err      <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      // NOTE: pulses default low every cycle; assignments further down override.
      frame_error <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      // Consumption; a delivery in the same cycle below re-sets rx_valid.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            phase <= 4'd0;
          end
        end

        START: begin
          if (tick) begin
            if (phase == 4'd7) begin
              if (rxs) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                phase   <= 4'd0;
                bit_cnt <= 3'd0;
`ifdef UART_RX_PARITY_EN
                par_err <= 1'b0;
`endif
              end
            end else begin
              phase <= phase + 4'd1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            phase <= phase + 4'd1;
            if (phase == 4'd15) begin
              shift   <= {rxs, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            phase <= phase + 4'd1;
            if (phase == 4'd15) begin
              par_err <= rxs ^ (^shift);
              state   <= STOP;
            end
          end
        end
`endif

        STOP: begin
          if (tick) begin
            phase <= phase + 4'd1;
            if (phase == 4'd15) begin
              state <= IDLE;
              if (!rxs) begin
                frame_error <= 1'b1;
              end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                parity_error <= 1'b1;
`endif
              end else if (rx_valid && !rx_ready) begin
                overrun <= 1'b1;
              end else begin
                rx_byte  <= shift;
                rx_valid <= 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus hand-written corner sequences; a
// monitor records every byte presented on rx_valid's rising edge and the main
// process compares those against the expected-byte queue.
module tb_uart_rx;

  localparam int BIT_CLKS = 32;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       serial_rx;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_error;
  logic       parity_error;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  int fe_cnt = 0;
  int pe_cnt = 0;
  int ov_cnt = 0;
  logic prev_valid = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] last_byte;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par_flip;
  } vec_t;

  vec_t vecs[7];

  uart_rx #(
    .CLOCK_HZ(3_200_000),
    .BAUD_HZ (100_000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .serial_rx   (serial_rx),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_error (frame_error),
    .parity_error(parity_error),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  // Monitor: count status pulse cycles and capture presented bytes.
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_error)  fe_cnt = fe_cnt + 1;
      if (parity_error) pe_cnt = pe_cnt + 1;
      if (overrun)      ov_cnt = ov_cnt + 1;
      if (rx_valid && !prev_valid) obs_q.push_back(rx_byte);
    end
    prev_valid = rx_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    serial_rx = b;
    tick_n(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^data) ^ par_flip);
`endif
    send_bit(stop);
    serial_rx = 1'b1;
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    tick_n(1);
    rx_ready = 1'b0;
    tick_n(1);
  endtask

  task automatic sb_compare();
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      check("sb_byte", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    end
    check("sb_missing", exp_q.size(), 0);
    check("sb_unexpected", obs_q.size(), 0);
  endtask

  initial begin
    int fe0, pe0, ov0;
    logic exp_fe, exp_pe, exp_v;

    vecs[0] = '{8'h41, 1'b1, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b0};
    vecs[5] = '{8'h41, 1'b1, 1'b1};
    vecs[6] = '{8'h3B, 1'b1, 1'b0};

    reset     = 1'b1;
    serial_rx = 1'b1;
    rx_ready  = 1'b0;
    last_byte = 8'h00;
    tick_n(4);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_parity_error", parity_error, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    tick_n(10);

    // Table-driven frames with rx_ready low, then a single ready pulse.
    for (int v = 0; v < 7; v++) begin
      exp_fe = !vecs[v].stop;
      exp_pe = PAR_EN && vecs[v].stop && vecs[v].par_flip;
      exp_v  = vecs[v].stop && !exp_pe;
      fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
      if (exp_v) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].par_flip);
      tick_n(100);
      if (exp_v) last_byte = vecs[v].data;
      check($sformatf("v%0d_valid", v), rx_valid, exp_v);
      check($sformatf("v%0d_byte", v), rx_byte, last_byte);
      check($sformatf("v%0d_frame_err", v), fe_cnt - fe0, exp_fe);
      check($sformatf("v%0d_parity_err", v), pe_cnt - pe0, exp_pe);
      check($sformatf("v%0d_overrun", v), ov_cnt - ov0, 0);
      sb_compare();
      pulse_ready();
      check($sformatf("v%0d_consumed", v), rx_valid, 0);
      check($sformatf("v%0d_byte_kept", v), rx_byte, last_byte);
      tick_n(20);
    end

    // Short low glitch on an idle line, then a real character.
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    serial_rx = 1'b0;
    tick_n(6);
    serial_rx = 1'b1;
    tick_n(80);
    check("glitch_valid", rx_valid, 0);
    check("glitch_errors", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);
    sb_compare();
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);
    tick_n(40);
    last_byte = 8'hC3;
    check("post_glitch_valid", rx_valid, 1);
    check("post_glitch_byte", rx_byte, 8'hC3);
    sb_compare();
    pulse_ready();

    // Back-to-back characters with no consumer: second one overruns.
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    tick_n(60);
    last_byte = 8'hA5;
    check("ovr_count", ov_cnt - ov0, 1);
    check("ovr_other_errors", (fe_cnt - fe0) + (pe_cnt - pe0), 0);
    check("ovr_valid", rx_valid, 1);
    check("ovr_byte", rx_byte, 8'hA5);
    sb_compare();
    pulse_ready();
    check("ovr_consumed", rx_valid, 0);

    // rx_ready held high: byte is consumed the cycle after it appears.
    rx_ready = 1'b1;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    tick_n(40);
    last_byte = 8'h5A;
    check("ready_hi_valid", rx_valid, 0);
    check("ready_hi_byte", rx_byte, 8'h5A);
    sb_compare();
    rx_ready = 1'b0;

    // Leave a byte unconsumed, then reset during bit 4 of 0xFF.
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, 1'b0);
    tick_n(40);
    check("pre_rst_valid", rx_valid, 1);
    sb_compare();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    tick_n(16);
    reset = 1'b1;
    tick_n(3);
    check("midrst_rx_byte", rx_byte, 8'h00);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_pulses", {frame_error, parity_error, overrun}, 3'b000);
    reset = 1'b0;
    tick_n(40);
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0);
    tick_n(40);
    check("post_rst_valid", rx_valid, 1);
    check("post_rst_byte", rx_byte, 8'h0F);
    check("post_rst_errors", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);
    sb_compare();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
